// File: rtl/simon_pkg.sv
// simon_pkg: shared constants and types for the Simon-says game engine.
package simon_pkg;

    // Colour codes and the blank code understood by the LCD controller.
    localparam logic [2:0] COLOR_0   = 3'd0;
    localparam logic [2:0] COLOR_1   = 3'd1;
    localparam logic [2:0] COLOR_2   = 3'd2;
    localparam logic [2:0] COLOR_3   = 3'd3;
    localparam logic [2:0] MSG_BLANK = 3'b100;

    // Feedback mask of the 16-bit Galois LFSR.
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Game controller states.
    typedef enum logic [2:0] {
        IDLE,
        GEN,
        SHOW,
        GAP,
        WAIT_IN,
        PAUSE,
        WIN,
        LOSE
    } state_t;

endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr: free-running 16-bit Galois LFSR; the low two bits are the colour.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] colour_o
);

    logic [15:0] lfsr_q;

    // Shift right every cycle, folding the mask in when a one falls out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else if (lfsr_q[0]) begin
            lfsr_q <= (lfsr_q >> 1) ^ LFSR_MASK;
        end else begin
            lfsr_q <= lfsr_q >> 1;
        end
    end

    assign colour_o = lfsr_q[1:0];

endmodule

// File: rtl/simon_sequence_player.sv
// simon_sequence_player: Simon-says game engine. Grows a random colour
// sequence by one per round, plays it back to the LCD as timed colour codes,
// then checks the player's presses against it.
// Optional build macro SIMON_TIMEOUT_EN: an idle player in WAIT_IN loses
// after TIMEOUT_TICKS cycles without a correct press.
module simon_sequence_player
    import simon_pkg::*;
#(
    parameter int          MAX_LEN       = 16,
    parameter int          SHOW_TICKS    = 50_000_000,
    parameter int          GAP_TICKS     = 12_500_000,
    parameter int          TIMEOUT_TICKS = 250_000_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_i,
    input  logic [3:0]                   btn_i,
    output logic                         ready_o,
    output logic [2:0]                   mensaje_o,
    output logic [$clog2(MAX_LEN+1)-1:0] level_o,
    output logic                         busy_o,
    output logic                         win_o,
    output logic                         lose_o
);

    localparam int LW = $clog2(MAX_LEN + 1);
    // One shared timer, sized for the longest interval it may ever count.
    localparam int TICK_MAX_SG = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TICK_MAX    = (TICK_MAX_SG > TIMEOUT_TICKS) ? TICK_MAX_SG : TIMEOUT_TICKS;
    localparam int TW          = $clog2(TICK_MAX + 1);

    localparam logic [LW-1:0] ONE_L     = LW'(1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
    localparam logic [TW-1:0] ONE_T     = TW'(1);
    localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_TICKS - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
`endif

    state_t        state, state_nxt;
    logic [LW-1:0] len, len_nxt;
    logic [LW-1:0] idx, idx_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    mensaje_nxt;
    logic          ready_nxt;
    logic          seq_we;
    logic          btn_ok;
    logic [1:0]    lfsr_colour;
    logic [1:0]    show_colour;
    // Power-of-two depth so the length-wide index covers the array exactly.
    logic [1:0]    seq [2**LW];

    simon_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .colour_o (lfsr_colour)
    );

    // Next-state, counters and next output values.
    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        idx_nxt   = idx;
        timer_nxt = timer;
        ready_nxt = ready_o;
        seq_we    = 1'b0;
        btn_ok    = (btn_i == (4'b0001 << seq[idx]));

        case (state)
            IDLE, WIN, LOSE: begin
                if (start_i) begin
                    state_nxt = GEN;
                    len_nxt   = '0;
                    timer_nxt = '0;
                    ready_nxt = 1'b1;
                end
            end
            GEN: begin
                seq_we    = 1'b1;
                len_nxt   = len + ONE_L;
                idx_nxt   = '0;
                timer_nxt = SHOW_LOAD;
                state_nxt = SHOW;
            end
            SHOW: begin
                if (timer == '0) begin
                    state_nxt = GAP;
                    timer_nxt = GAP_LOAD;
                end else begin
                    timer_nxt = timer - ONE_T;
                end
            end
            GAP: begin
                if (timer != '0) begin
                    timer_nxt = timer - ONE_T;
                end else if (idx == len - ONE_L) begin
                    state_nxt = WAIT_IN;
                    idx_nxt   = '0;
                    timer_nxt = '0;
                end else begin
                    state_nxt = SHOW;
                    idx_nxt   = idx + ONE_L;
                    timer_nxt = SHOW_LOAD;
                end
            end
            WAIT_IN: begin
                // A press always takes priority over a coincident start or timeout.
                if (btn_i != 4'b0000) begin
                    timer_nxt = '0;
                    if (!btn_ok) begin
                        state_nxt = LOSE;
                    end else if (idx < len - ONE_L) begin
                        idx_nxt = idx + ONE_L;
                    end else if (len == LEN_MAX) begin
                        state_nxt = WIN;
                    end else begin
                        state_nxt = PAUSE;
                        timer_nxt = GAP_LOAD;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (timer == TIMEOUT_LAST) begin
                    state_nxt = LOSE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + ONE_T;
                end
`endif
            end
            PAUSE: begin
                if (timer == '0) begin
                    state_nxt = GEN;
                end else begin
                    timer_nxt = timer - ONE_T;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Leaving GEN for SHOW, seq[len] is only being written this cycle, so bypass it.
        show_colour = ((state == GEN) && (idx_nxt == len)) ? lfsr_colour : seq[idx_nxt];
        mensaje_nxt = (state_nxt == SHOW) ? {1'b0, show_colour} : MSG_BLANK;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            timer     <= '0;
            mensaje_o <= MSG_BLANK;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
            win_o     <= 1'b0;
            lose_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            idx       <= idx_nxt;
            timer     <= timer_nxt;
            mensaje_o <= mensaje_nxt;
            ready_o   <= ready_nxt;
            busy_o    <= state_nxt inside {GEN, SHOW, GAP, PAUSE};
            win_o     <= (state_nxt == WIN);
            lose_o    <= (state_nxt == LOSE);
        end
    end

    // Sequence memory: appended once per round, contents irrelevant after reset.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq[len] <= lfsr_colour;
        end
    end

    assign level_o = len;

endmodule

// File: tb/tb_simon_sequence_player.sv
// tb_simon_sequence_player: randomized self-checking bench for simon_sequence_player.
module tb_simon_sequence_player;

    localparam int          MAX_LEN       = 3;
    localparam int          SHOW_TICKS    = 4;
    localparam int          GAP_TICKS     = 2;
    localparam int          TIMEOUT_TICKS = 20;
    localparam logic [15:0] SEED          = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [3:0] btn_i;
    logic       ready_o;
    logic [2:0] mensaje_o;
    logic [1:0] level_o;
    logic       busy_o;
    logic       win_o;
    logic       lose_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] ref_lfsr;
    logic [1:0]  exp_seq[$];

    simon_sequence_player #(
        .MAX_LEN       (MAX_LEN),
        .SHOW_TICKS    (SHOW_TICKS),
        .GAP_TICKS     (GAP_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .btn_i     (btn_i),
        .ready_o   (ready_o),
        .mensaje_o (mensaje_o),
        .level_o   (level_o),
        .busy_o    (busy_o),
        .win_o     (win_o),
        .lose_o    (lose_o)
    );

    always #5 clk = ~clk;

    // Galois LFSR step: shift right, xor the tap mask when bit 0 was set.
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) ref_lfsr <= SEED;
        else       ref_lfsr <= lfsr_step(ref_lfsr);
    end

    always @(negedge clk) begin
        if (!reset) begin
            n_cmp++;
            if (dut.u_lfsr.lfsr_q !== ref_lfsr) begin
                n_bad++;
                $display("FAIL lfsr: got %h want %h", dut.u_lfsr.lfsr_q, ref_lfsr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Pulse start from IDLE/WIN/LOSE and check the GEN cycle; records the new colour.
    task automatic do_start(input int idle);
        repeat (idle) @(negedge clk);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        exp_seq.delete();
        exp_seq.push_back(ref_lfsr[1:0]);
        n_cmp++;
        if ({ready_o, busy_o, win_o, lose_o, level_o, mensaje_o} !== {4'b1100, 2'd0, 3'b100}) begin
            n_bad++;
            $display("FAIL gen_after_start: got rdy/busy/win/lose/lvl/msg=%b want 1100_00_100",
                     {ready_o, busy_o, win_o, lose_o, level_o, mensaje_o});
        end
    endtask

    // From the GEN cycle: check n colours (4 cycles each) and blanks (2 each), then WAIT_IN.
    task automatic playback(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < SHOW_TICKS; k++) begin
                @(negedge clk);
                start_i = 1'b0;
                btn_i   = noise ? 4'($urandom_range(1, 15)) : 4'b0000;
                n_cmp++;
                if ({busy_o, win_o, lose_o, level_o, mensaje_o} !== {3'b100, 2'(n), 1'b0, exp_seq[i]}) begin
                    n_bad++;
                    $display("FAIL show r%0d i%0d k%0d: got busy/win/lose/lvl/msg=%b want %b", n, i, k,
                             {busy_o, win_o, lose_o, level_o, mensaje_o},
                             {3'b100, 2'(n), 1'b0, exp_seq[i]});
                end
            end
            for (int k = 0; k < GAP_TICKS; k++) begin
                @(negedge clk);
                btn_i   = 4'b0000;
                start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                n_cmp++;
                if ({busy_o, win_o, lose_o, level_o, mensaje_o} !== {3'b100, 2'(n), 3'b100}) begin
                    n_bad++;
                    $display("FAIL gap r%0d i%0d k%0d: got busy/win/lose/lvl/msg=%b want %b", n, i, k,
                             {busy_o, win_o, lose_o, level_o, mensaje_o}, {3'b100, 2'(n), 3'b100});
                end
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        btn_i   = 4'b0000;
        n_cmp++;
        if ({busy_o, win_o, lose_o, level_o, mensaje_o} !== {3'b000, 2'(n), 3'b100}) begin
            n_bad++;
            $display("FAIL wait_entry r%0d: got busy/win/lose/lvl/msg=%b want %b", n,
                     {busy_o, win_o, lose_o, level_o, mensaje_o}, {3'b000, 2'(n), 3'b100});
        end
    endtask

    // From the first WAIT_IN cycle of round n: press every colour correctly,
    // then follow PAUSE/GEN into the next playback or check the win.
    task automatic press_round(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g <= gap; g++) begin
                @(negedge clk);
                btn_i = 4'b0000;
                n_cmp++;
                if ({busy_o, win_o, lose_o, mensaje_o} !== 6'b000_100) begin
                    n_bad++;
                    $display("FAIL waiting r%0d i%0d: got busy/win/lose/msg=%b want 000100", n, i,
                             {busy_o, win_o, lose_o, mensaje_o});
                end
            end
            btn_i = 4'b0001 << exp_seq[i];
        end
        @(negedge clk);
        btn_i = 4'b0000;
        if (n == MAX_LEN) begin
            n_cmp++;
            if ({busy_o, win_o, lose_o, level_o, mensaje_o} !== {3'b010, 2'(n), 3'b100}) begin
                n_bad++;
                $display("FAIL win: got busy/win/lose/lvl/msg=%b want %b",
                         {busy_o, win_o, lose_o, level_o, mensaje_o}, {3'b010, 2'(n), 3'b100});
            end
        end else begin
            for (int p = 0; p < GAP_TICKS; p++) begin
                if (p > 0) @(negedge clk);
                n_cmp++;
                if ({busy_o, win_o, lose_o, mensaje_o} !== 6'b100_100) begin
                    n_bad++;
                    $display("FAIL pause r%0d p%0d: got busy/win/lose/msg=%b want 100100", n, p,
                             {busy_o, win_o, lose_o, mensaje_o});
                end
            end
            @(negedge clk);
            exp_seq.push_back(ref_lfsr[1:0]);
            n_cmp++;
            if ({busy_o, level_o, mensaje_o} !== {1'b1, 2'(n), 3'b100}) begin
                n_bad++;
                $display("FAIL gen r%0d: got busy/lvl/msg=%b want %b", n,
                         {busy_o, level_o, mensaje_o}, {1'b1, 2'(n), 3'b100});
            end
            playback(n + 1, noise);
        end
    endtask

    task automatic test_reset;
        reset   = 1'b0;
        start_i = 1'b0;
        btn_i   = 4'b0000;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ready_o, busy_o, win_o, lose_o, level_o, mensaje_o} !== {4'b0000, 2'd0, 3'b100}) begin
            n_bad++;
            $display("FAIL reset_values: got %b want 0000_00_100",
                     {ready_o, busy_o, win_o, lose_o, level_o, mensaje_o});
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ready_o, busy_o, win_o, lose_o, level_o, mensaje_o} !== {4'b0000, 2'd0, 3'b100}) begin
                n_bad++;
                $display("FAIL idle c%0d: got %b want 0000_00_100", c,
                         {ready_o, busy_o, win_o, lose_o, level_o, mensaje_o});
            end
        end
    endtask

    task automatic test_start;
        do_start($urandom_range(0, 7));
        playback(1, 1'b0);
    endtask

    task automatic test_full_game;
        for (int r = 1; r <= MAX_LEN; r++) press_round(r, 1'b0);
    endtask

    task automatic test_wrong_colour;
        logic [1:0] bad;
        // Restart from WIN, then a wrong colour together with start: the press wins.
        do_start($urandom_range(0, 5));
        playback(1, 1'b0);
        bad     = exp_seq[0] + 2'($urandom_range(1, 3));
        btn_i   = 4'b0001 << bad;
        start_i = 1'b1;
        @(negedge clk);
        btn_i   = 4'b0000;
        start_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            n_cmp++;
            if ({busy_o, win_o, lose_o, mensaje_o} !== 6'b001_100) begin
                n_bad++;
                $display("FAIL lose_wrong c%0d: got busy/win/lose/msg=%b want 001100", c,
                         {busy_o, win_o, lose_o, mensaje_o});
            end
        end
        // Restart from LOSE, then a wrong colour on the second element of round 2.
        do_start($urandom_range(0, 5));
        playback(1, 1'b0);
        press_round(1, 1'b0);
        btn_i = 4'b0001 << exp_seq[0];
        @(negedge clk);
        bad   = exp_seq[1] + 2'($urandom_range(1, 3));
        btn_i = 4'b0001 << bad;
        n_cmp++;
        if ({busy_o, win_o, lose_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_round_correct: got busy/win/lose=%b want 000", {busy_o, win_o, lose_o});
        end
        @(negedge clk);
        btn_i = 4'b0000;
        n_cmp++;
        if ({busy_o, win_o, lose_o, level_o} !== {3'b001, 2'd2}) begin
            n_bad++;
            $display("FAIL lose_second: got busy/win/lose/lvl=%b want 00110", {busy_o, win_o, lose_o, level_o});
        end
    endtask

    task automatic test_multi_bit;
        do_start($urandom_range(0, 5));
        playback(1, 1'b0);
        btn_i = 4'b0011;
        @(negedge clk);
        btn_i = 4'b0000;
        n_cmp++;
        if ({busy_o, win_o, lose_o, mensaje_o} !== 6'b001_100) begin
            n_bad++;
            $display("FAIL lose_multi: got busy/win/lose/msg=%b want 001100", {busy_o, win_o, lose_o, mensaje_o});
        end
        do_start($urandom_range(0, 5));
        playback(1, 1'b0);
    endtask

    task automatic test_ignored_inputs;
        // Current state is WAIT_IN of round 1 from the previous test; lose it cleanly first.
        btn_i = 4'b1111;
        @(negedge clk);
        btn_i = 4'b0000;
        do_start($urandom_range(0, 5));
        playback(1, 1'b1);
        press_round(1, 1'b1);
        // start in WAIT_IN is ignored as well
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n_cmp++;
        if ({busy_o, win_o, lose_o, level_o, mensaje_o} !== {3'b000, 2'd2, 3'b100}) begin
            n_bad++;
            $display("FAIL start_in_wait: got %b want 000_10_100", {busy_o, win_o, lose_o, level_o, mensaje_o});
        end
        btn_i = 4'b1111;
        @(negedge clk);
        btn_i = 4'b0000;
    endtask

    task automatic test_timeout;
        do_start($urandom_range(0, 5));
        playback(1, 1'b0);
`ifdef SIMON_TIMEOUT_EN
        for (int c = 1; c < TIMEOUT_TICKS; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy_o, lose_o} !== 2'b00) begin
                n_bad++;
                $display("FAIL timeout_early c%0d: got busy/lose=%b want 00", c, {busy_o, lose_o});
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({busy_o, win_o, lose_o} !== 3'b001) begin
            n_bad++;
            $display("FAIL timeout_lose: got busy/win/lose=%b want 001", {busy_o, win_o, lose_o});
        end
`else
        for (int c = 1; c <= 2 * TIMEOUT_TICKS; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy_o, lose_o} !== 2'b00) begin
                n_bad++;
                $display("FAIL no_timeout c%0d: got busy/lose=%b want 00", c, {busy_o, lose_o});
            end
        end
        btn_i = 4'b0001 << exp_seq[0];
        @(negedge clk);
        btn_i = 4'b0000;
        n_cmp++;
        if ({busy_o, win_o, lose_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL late_press: got busy/win/lose=%b want 100", {busy_o, win_o, lose_o});
        end
`endif
    endtask

    task automatic test_reset_mid_show;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_start($urandom_range(0, 5));
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy_o, mensaje_o} !== {2'b10, exp_seq[0]}) begin
            n_bad++;
            $display("FAIL pre_reset_show: got busy/msg=%b want %b", {busy_o, mensaje_o}, {2'b10, exp_seq[0]});
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({ready_o, busy_o, win_o, lose_o, level_o, mensaje_o} !== {4'b0000, 2'd0, 3'b100}) begin
            n_bad++;
            $display("FAIL async_reset: got %b want 0000_00_100",
                     {ready_o, busy_o, win_o, lose_o, level_o, mensaje_o});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ready_o, busy_o, win_o, lose_o, level_o, mensaje_o} !== {4'b0000, 2'd0, 3'b100}) begin
                n_bad++;
                $display("FAIL idle_after_reset c%0d: got %b want 0000_00_100", c,
                         {ready_o, busy_o, win_o, lose_o, level_o, mensaje_o});
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_full_game();
        test_wrong_colour();
        test_multi_bit();
        test_ignored_inputs();
        test_timeout();
        test_reset_mid_show();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
